// File: rtl/i_exp_arbiter_pkg.sv
// Shared definitions for the i_exp arbiter: default widths, FSM state
// encoding and the round-robin pointer helper.
package i_exp_arbiter_pkg;

  localparam int N_REQ_DEF   = 4;
  localparam int Q_WIDTH_DEF = 32;
  localparam int S_WIDTH_DEF = 16;
  localparam int M_WIDTH_DEF = 6;
  localparam int TIMEOUT_DEF = 1024;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Index of the requester after idx, wrapping at n.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/i_exp_arbiter_if.sv
// Bus between the arbiter and the single i_exp unit.
//  start  : level request to i_exp, held until done is seen
//  q/S/maxmsb : operands, stable while start is high
//  q_out/S_out/done : result and completion flag from i_exp
// master = arbiter side, slave = i_exp side.
interface i_exp_arbiter_if import i_exp_arbiter_pkg::*; #(
  parameter int Q_WIDTH = Q_WIDTH_DEF,
  parameter int S_WIDTH = S_WIDTH_DEF,
  parameter int M_WIDTH = M_WIDTH_DEF
) ();
  logic                      start;
  logic signed [Q_WIDTH-1:0] q;
  logic signed [S_WIDTH-1:0] S;
  logic [M_WIDTH-1:0]        maxmsb;
  logic signed [Q_WIDTH-1:0] q_out;
  logic signed [S_WIDTH-1:0] S_out;
  logic                      done;

  modport master (output start, q, S, maxmsb, input q_out, S_out, done);
  modport slave  (input start, q, S, maxmsb, output q_out, S_out, done);
endinterface

// File: rtl/i_exp_arbiter_rr_arbiter.sv
// Round-robin pick: first asserted request at or after ptr, wrapping.
//  req : request vector       ptr : search start index
//  gnt : one-hot winner       idx : winner index      any : some request set
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);
  localparam int IDX_W = $clog2(N);

  // Scan N positions starting at ptr; the first hit wins.
  always_comb begin
    int c;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    c   = 0;
    for (int k = 0; k < N; k++) begin
      c = int'(ptr) + k;
      if (c >= N) begin
        c = c - N;
      end else begin
        c = c;
      end
      if (!any && req[c]) begin
        gnt[c] = 1'b1;
        idx    = IDX_W'(c);
        any    = 1'b1;
      end else begin
        any = any;
      end
    end
  end
endmodule

// File: rtl/i_exp_arbiter.sv
// Shares one i_exp unit between N_REQ requesters with round-robin grant.
//  clk, rst    : clock, synchronous active-high reset
//  req_*       : per-requester valid and packed operands (slice i = requester i)
//  req_ready   : one-hot accept strobe, combinational in IDLE
//  rsp_*       : one-cycle result strobe with id, result and timeout flag
//  exp_bus     : master side of the i_exp bus
module i_exp_arbiter import i_exp_arbiter_pkg::*; #(
  parameter int N_REQ          = N_REQ_DEF,
  parameter int Q_WIDTH        = Q_WIDTH_DEF,
  parameter int S_WIDTH        = S_WIDTH_DEF,
  parameter int M_WIDTH        = M_WIDTH_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*Q_WIDTH-1:0]   req_q,
  input  logic [N_REQ*S_WIDTH-1:0]   req_S,
  input  logic [N_REQ*M_WIDTH-1:0]   req_maxmsb,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       rsp_valid,
  output logic [$clog2(N_REQ)-1:0]   rsp_id,
  output logic signed [Q_WIDTH-1:0]  rsp_q,
  output logic signed [S_WIDTH-1:0]  rsp_S,
  output logic                       rsp_err,
  i_exp_arbiter_if.master            exp_bus
);
  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  state_t                    state_r;
  logic [ID_W-1:0]           ptr_r;
  logic [ID_W-1:0]           id_r;
  logic [CNT_W-1:0]          cnt_r;
  logic                      start_r;
  logic signed [Q_WIDTH-1:0] op_q_r;
  logic signed [S_WIDTH-1:0] op_s_r;
  logic [M_WIDTH-1:0]        op_m_r;

  logic [N_REQ-1:0]          gnt_s;
  logic [ID_W-1:0]           gnt_idx_s;
  logic                      gnt_any_s;
  logic [Q_WIDTH-1:0]        sel_q_s;
  logic [S_WIDTH-1:0]        sel_s_s;
  logic [M_WIDTH-1:0]        sel_m_s;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .req (req_valid),
    .ptr (ptr_r),
    .gnt (gnt_s),
    .idx (gnt_idx_s),
    .any (gnt_any_s)
  );

  // Operand slices of the current round-robin winner.
  always_comb begin
    sel_q_s = req_q[int'(gnt_idx_s)*Q_WIDTH +: Q_WIDTH];
    sel_s_s = req_S[int'(gnt_idx_s)*S_WIDTH +: S_WIDTH];
    sel_m_s = req_maxmsb[int'(gnt_idx_s)*M_WIDTH +: M_WIDTH];
  end

  // Accept strobe only while idle and out of reset, so a request is never
  // acknowledged in a cycle where it cannot be latched.
  always_comb begin
    if (state_r == ST_IDLE && !rst) begin
      req_ready = gnt_s;
    end else begin
      req_ready = '0;
    end
  end

  // Main FSM: grant, wait for done or timeout, then drain until done drops
  // so a stale done cannot complete the next job.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      ptr_r     <= '0;
      id_r      <= '0;
      cnt_r     <= '0;
      start_r   <= 1'b0;
      op_q_r    <= '0;
      op_s_r    <= '0;
      op_m_r    <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_q     <= '0;
      rsp_S     <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          rsp_valid <= 1'b0;
          if (gnt_any_s) begin
            op_q_r  <= sel_q_s;
            op_s_r  <= sel_s_s;
            op_m_r  <= sel_m_s;
            id_r    <= gnt_idx_s;
            ptr_r   <= ID_W'(rr_next(int'(gnt_idx_s), N_REQ));
            cnt_r   <= '0;
            start_r <= 1'b1;
            state_r <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // done takes priority over a timeout landing in the same cycle
          if (exp_bus.done) begin
            rsp_q     <= exp_bus.q_out;
            rsp_S     <= exp_bus.S_out;
            rsp_id    <= id_r;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            start_r   <= 1'b0;
            state_r   <= ST_DRAIN;
          end else if (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            rsp_q     <= '0;
            rsp_S     <= '0;
            rsp_id    <= id_r;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            start_r   <= 1'b0;
            state_r   <= ST_DRAIN;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_DRAIN: begin
          rsp_valid <= 1'b0;
          if (!exp_bus.done) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          start_r   <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

  assign exp_bus.start  = start_r;
  assign exp_bus.q      = op_q_r;
  assign exp_bus.S      = op_s_r;
  assign exp_bus.maxmsb = op_m_r;
endmodule

// File: tb/tb_i_exp_arbiter.sv
// Randomized and directed bench for i_exp_arbiter with a transaction-level
// reference model and a behavioural i_exp stand-in.
module tb_i_exp_arbiter;
  localparam int N  = 4;
  localparam int QW = 32;
  localparam int SW = 16;
  localparam int MW = 6;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*QW-1:0] req_q = '0;
  logic [N*SW-1:0] req_S = '0;
  logic [N*MW-1:0] req_maxmsb = '0;
  logic [N-1:0]    req_ready;
  logic            rsp_valid;
  logic [1:0]      rsp_id;
  logic signed [QW-1:0] rsp_q;
  logic signed [SW-1:0] rsp_S;
  logic            rsp_err;

  i_exp_arbiter_if #(.Q_WIDTH(QW), .S_WIDTH(SW), .M_WIDTH(MW)) exp_if ();

  i_exp_arbiter #(.N_REQ(N), .Q_WIDTH(QW), .S_WIDTH(SW), .M_WIDTH(MW),
                  .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_q(req_q), .req_S(req_S),
    .req_maxmsb(req_maxmsb), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_id(rsp_id), .rsp_q(rsp_q), .rsp_S(rsp_S), .rsp_err(rsp_err),
    .exp_bus(exp_if.master)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // stimulus controls
  logic          rst_req = 1'b1;
  logic          rand_mode = 1'b0;
  logic [N-1:0]  fixed_vld = '0;
  logic [QW-1:0] op_q [N];
  logic [SW-1:0] op_s [N];
  logic [MW-1:0] op_m [N];

  // reference model
  logic          free_m = 1'b0, outstanding_m = 1'b0, drain_m = 1'b0;
  int            ptr_m = 0, id_m = 0, kc = 0;
  logic [QW-1:0] lat_q; logic [SW-1:0] lat_s; logic [MW-1:0] lat_m;
  logic [1:0]    last_id = '0; logic [QW-1:0] last_q = '0; logic [SW-1:0] last_s = '0;
  int            grant_cnt = 0, dropped = 0;

  // i_exp stand-in
  logic          em_nodone = 1'b0, em_served = 1'b0, last_done = 1'b0;
  int            em_lat = 2, em_hold = 1, em_wait = 0, em_hold_left = 0;
  logic [QW-1:0] em_qo = '0; logic [SW-1:0] em_so = '0;

  // DUT observations
  int            cyc = 0, dut_rsp_cnt = 0, rsp_cyc = 0, start_cyc = 0;
  logic          prev_start = 1'b0, cap_err = 1'b0, cap_start = 1'b0;
  logic [QW-1:0] cap_q = '0;
  int            dut_gnt_q [$];

  function automatic logic [QW-1:0] fq(input logic [QW-1:0] q, input logic [SW-1:0] s, input logic [MW-1:0] m);
    return (q * 32'd3 + {26'd0, m}) ^ {16'd0, s};
  endfunction

  function automatic logic [SW-1:0] fs(input logic [SW-1:0] s, input logic [MW-1:0] m);
    return s ^ 16'h5A5A ^ {10'd0, m};
  endfunction

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // One clock: check registered outputs, run the i_exp stand-in, drive
  // inputs, then check the combinational accept strobe before the edge.
  task automatic step();
    logic         rst_prev, exp_rsp, done_n;
    logic [N-1:0] exp_rdy;
    int           g;
    @(negedge clk);
    cyc++;
    rst_prev = rst;
    if (rst_prev) begin
      chk("rst_start", exp_if.start, 1'b0);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_rsp_q", $unsigned(rsp_q), 0);
      if (outstanding_m) dropped++;
      free_m = 1'b1; outstanding_m = 1'b0; drain_m = 1'b0; ptr_m = 0;
      last_id = '0; last_q = '0; last_s = '0;
    end else begin
      if (drain_m && !last_done) begin free_m = 1'b1; drain_m = 1'b0; end
      exp_rsp = 1'b0;
      if (outstanding_m) begin
        kc++;
        if (kc >= 1 && (last_done || kc == TO)) exp_rsp = 1'b1;
      end
      chk("rsp_valid", rsp_valid, exp_rsp);
      if (rsp_valid) begin
        dut_rsp_cnt++; cap_q = $unsigned(rsp_q); cap_err = rsp_err;
        cap_start = exp_if.start; rsp_cyc = cyc;
      end
      if (exp_rsp) begin
        last_id = 2'(id_m);
        last_q  = last_done ? fq(lat_q, lat_s, lat_m) : '0;
        last_s  = last_done ? fs(lat_s, lat_m) : '0;
        chk("rsp_err", rsp_err, !last_done);
        outstanding_m = 1'b0; drain_m = 1'b1;
      end
      chk("rsp_id", rsp_id, last_id);
      chk("rsp_q", $unsigned(rsp_q), last_q);
      chk("rsp_S", $unsigned(rsp_S), last_s);
      chk("exp_start", exp_if.start, outstanding_m);
      if (outstanding_m) begin
        chk("exp_q", $unsigned(exp_if.q), lat_q);
        chk("exp_S", $unsigned(exp_if.S), lat_s);
        chk("exp_maxmsb", exp_if.maxmsb, lat_m);
      end
    end
    if (exp_if.start && !prev_start) start_cyc = cyc;
    prev_start = exp_if.start;
    // i_exp stand-in: raise done em_lat cycles after start, hold it em_hold cycles
    if (rst_prev) begin
      em_served = 1'b0; em_wait = 0; em_hold_left = 0;
    end else if (!exp_if.start) begin
      em_served = 1'b0; em_wait = 0;
      if (rand_mode) begin
        em_lat = $urandom_range(0, 4);
        em_nodone = ($urandom_range(0, 7) == 0);
      end
    end else if (!em_served && !em_nodone) begin
      if (em_wait >= em_lat) begin
        em_served = 1'b1;
        em_hold_left = rand_mode ? int'($urandom_range(1, 3)) : em_hold;
        em_qo = fq($unsigned(exp_if.q), $unsigned(exp_if.S), exp_if.maxmsb);
        em_so = fs($unsigned(exp_if.S), exp_if.maxmsb);
      end else begin
        em_wait++;
      end
    end
    done_n = (em_hold_left > 0);
    if (done_n) em_hold_left--;
    last_done = done_n;
    exp_if.done = done_n; exp_if.q_out = em_qo; exp_if.S_out = em_so;
    // requester stimulus
    rst = rst_req;
    if (rand_mode) begin
      for (int i = 0; i < N; i++) begin
        req_valid[i] = ($urandom_range(0, 9) < 4);
        op_q[i] = $urandom(); op_s[i] = 16'($urandom()); op_m[i] = 6'($urandom());
      end
    end else begin
      req_valid = fixed_vld;
    end
    for (int i = 0; i < N; i++) begin
      req_q[i*QW +: QW] = op_q[i]; req_S[i*SW +: SW] = op_s[i]; req_maxmsb[i*MW +: MW] = op_m[i];
    end
    #1;
    exp_rdy = '0; g = -1;
    if (!rst && free_m && (|req_valid)) begin
      g = pick(req_valid, ptr_m);
      exp_rdy = {{(N-1){1'b0}}, 1'b1} << g;
    end
    chk("req_ready", req_ready, exp_rdy);
    for (int i = 0; i < N; i++) if (req_ready[i]) dut_gnt_q.push_back(i);
    if (g >= 0) begin
      lat_q = op_q[g]; lat_s = op_s[g]; lat_m = op_m[g];
      id_m = g; ptr_m = (g + 1) % N; free_m = 1'b0; outstanding_m = 1'b1; kc = -1;
      grant_cnt++;
    end
  endtask

  task automatic wait_grants(input int target, input int budget);
    int n = 0;
    while (grant_cnt < target && n < budget) begin step(); n++; end
    chk("grant_wait", grant_cnt, target);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!free_m && n < budget) begin step(); n++; end
    chk("idle_wait", free_m, 1'b1);
  endtask

  task automatic do_reset();
    rst_req = 1'b1; step(); step();
    rst_req = 1'b0; step();
  endtask

  initial begin
    int r0;
    for (int i = 0; i < N; i++) begin op_q[i] = '0; op_s[i] = '0; op_m[i] = '0; end
    exp_if.done = 1'b0; exp_if.q_out = '0; exp_if.S_out = '0;
    do_reset();
    chk("reset_rsp_id", rsp_id, 2'd0);
    chk("reset_exp_q", $unsigned(exp_if.q), 0);

    // single request from requester 0
    em_lat = 3; em_hold = 1;
    op_q[0] = 32'd5; op_s[0] = 16'd512; op_m[0] = 6'd25;
    fixed_vld = 4'b0001; dut_gnt_q.delete();
    wait_grants(grant_cnt + 1, 20);
    fixed_vld = 4'b0000;
    wait_idle(40);
    chk("t1_grant", dut_gnt_q.size() > 0 ? dut_gnt_q[0] : -1, 0);
    chk("t1_rsp_q", cap_q, fq(32'd5, 16'd512, 6'd25));
    chk("t1_err", cap_err, 1'b0);

    // all four requesting: service order 0,1,2,3 then wrap to 0
    do_reset();
    em_lat = 2;
    for (int i = 0; i < N; i++) begin op_q[i] = 32'(5 * (i + 1)); op_s[i] = 16'(512 + i); op_m[i] = 6'd25; end
    fixed_vld = 4'b1111; dut_gnt_q.delete();
    wait_grants(grant_cnt + 5, 80);
    fixed_vld = 4'b0000;
    wait_idle(40);
    for (int i = 0; i < 5; i++) chk("t2_order", dut_gnt_q.size() > i ? dut_gnt_q[i] : -1, i % N);

    // req1 held, req2 raised mid-job: 1,2,1
    em_lat = 4;
    fixed_vld = 4'b0010; dut_gnt_q.delete();
    wait_grants(grant_cnt + 1, 20);
    step(); step();
    fixed_vld = 4'b0110;
    wait_grants(grant_cnt + 2, 60);
    fixed_vld = 4'b0000;
    wait_idle(40);
    chk("t3_g0", dut_gnt_q.size() > 0 ? dut_gnt_q[0] : -1, 1);
    chk("t3_g1", dut_gnt_q.size() > 1 ? dut_gnt_q[1] : -1, 2);
    chk("t3_g2", dut_gnt_q.size() > 2 ? dut_gnt_q[2] : -1, 1);

    // i_exp never answers: timeout error 16 cycles after start
    em_nodone = 1'b1; fixed_vld = 4'b0001;
    wait_grants(grant_cnt + 1, 20);
    fixed_vld = 4'b0000;
    wait_idle(60);
    em_nodone = 1'b0;
    chk("t4_err", cap_err, 1'b1);
    chk("t4_q", cap_q, 0);
    chk("t4_start_low", cap_start, 1'b0);
    chk("t4_latency", rsp_cyc - start_cyc, TO);

    // done arrives in the timeout cycle: done wins
    em_lat = TO - 1; fixed_vld = 4'b0001;
    wait_grants(grant_cnt + 1, 20);
    fixed_vld = 4'b0000;
    wait_idle(60);
    chk("t5_err", cap_err, 1'b0);
    chk("t5_latency", rsp_cyc - start_cyc, TO);

    // done held 3 cycles: one response per job, no early re-grant
    em_lat = 1; em_hold = 3; r0 = dut_rsp_cnt; fixed_vld = 4'b0001;
    wait_grants(grant_cnt + 2, 40);
    fixed_vld = 4'b0000;
    wait_idle(40);
    chk("t6_rsp_count", dut_rsp_cnt - r0, 2);
    em_hold = 1;

    // reset while busy drops the job and returns the pointer to 0
    em_nodone = 1'b1; fixed_vld = 4'b0100;
    wait_grants(grant_cnt + 1, 20);
    fixed_vld = 4'b0000;
    step(); step(); step();
    rst_req = 1'b1; step();
    rst_req = 1'b0; step();
    em_nodone = 1'b0; em_lat = 2; fixed_vld = 4'b1010; dut_gnt_q.delete();
    wait_grants(grant_cnt + 1, 20);
    fixed_vld = 4'b0000;
    wait_idle(40);
    chk("t7_grant", dut_gnt_q.size() > 0 ? dut_gnt_q[0] : -1, 1);

    // randomized traffic
    rand_mode = 1'b1;
    for (int i = 0; i < 3000; i++) step();
    rand_mode = 1'b0; em_nodone = 1'b0; fixed_vld = 4'b0000;
    wait_idle(100);
    step(); step();
    chk("rsp_total", dut_rsp_cnt, grant_cnt - dropped);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
